// File: rtl/delay_and_sum_sdiv_53s_16s_seq_if.sv
// Handshake and data bundle for the sequential signed divider.
//   master: drives ce, start, din0, din1; observes busy, done and results.
//   slave : the divider side.
interface delay_and_sum_sdiv_53s_16s_seq_if #(
  parameter int din0_WIDTH = 53,
  parameter int din1_WIDTH = 16,
  parameter int dout_WIDTH = 41
);
  logic                  ce;
  logic                  start;
  logic [din0_WIDTH-1:0] din0;
  logic [din1_WIDTH-1:0] din1;
  logic                  busy;
  logic                  done;
  logic [dout_WIDTH-1:0] dout;
  logic [din1_WIDTH-1:0] remd;
  logic                  ovf;
  logic                  div_by_zero;

  modport master (
    output ce, start, din0, din1,
    input  busy, done, dout, remd, ovf, div_by_zero
  );

  modport slave (
    input  ce, start, din0, din1,
    output busy, done, dout, remd, ovf, div_by_zero
  );
endinterface

// File: rtl/delay_and_sum_sdiv_53s_16s_seq.sv
// Sequential signed divider (53s / 16s -> 41s quotient, 16s remainder).
// Radix-2 restoring division on magnitudes, one quotient bit per ce cycle,
// followed by a single sign-fix cycle.
//   clk   : rising-edge clock
//   reset : synchronous, active-high
//   io    : ce/start/din0/din1 in; busy/done/dout/remd/ovf/div_by_zero out
// Quotient truncates toward zero; remainder takes the sign of the dividend.
// A zero divisor skips the iterations: dout=0, remd=din0[15:0], div_by_zero=1.
module delay_and_sum_sdiv_53s_16s_seq #(
  parameter int ID         = 1,
  parameter int NUM_STAGE  = 55,
  parameter int din0_WIDTH = 53,
  parameter int din1_WIDTH = 16,
  parameter int dout_WIDTH = 41
) (
  input logic clk,
  input logic reset,
  delay_and_sum_sdiv_53s_16s_seq_if.slave io
);

  localparam int N = din0_WIDTH;
  localparam int D = din1_WIDTH;
  // ID and NUM_STAGE are informational tags; folded in here so they are referenced.
  localparam int CW = $clog2(N) + 0 * (ID + NUM_STAGE);
  localparam logic [N-1:0] LIM = N'(1) << (dout_WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t        state;
  logic [N-1:0]  q;      // dividend magnitude shifting out, quotient shifting in
  logic [D:0]    r;      // partial remainder
  logic [D:0]    dvs;    // divisor magnitude (0 marks divide by zero)
  logic [CW-1:0] cnt;
  logic          qneg;
  logic          rneg;

  logic [N-1:0]  a_abs;
  logic [D:0]    b_abs;
  logic [D:0]    r_sh;
  logic [D:0]    r_nx;
  logic          ge;
  logic          zdiv;

  always_comb begin
    a_abs = io.din0[N-1] ? -io.din0 : io.din0;
    b_abs = {1'b0, (io.din1[D-1] ? -io.din1 : io.din1)};
    r_sh  = {r[D-1:0], q[N-1]};
    ge    = (r_sh >= dvs);
    r_nx  = ge ? (r_sh - dvs) : r_sh;
    zdiv  = (dvs == '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      q              <= '0;
      r              <= '0;
      dvs            <= '0;
      cnt            <= '0;
      qneg           <= 1'b0;
      rneg           <= 1'b0;
      io.busy        <= 1'b0;
      io.done        <= 1'b0;
      io.dout        <= '0;
      io.remd        <= '0;
      io.ovf         <= 1'b0;
      io.div_by_zero <= 1'b0;
    end else if (io.ce) begin
      case (state)
        IDLE: begin
          io.done <= 1'b0;
          if (io.start) begin
            q       <= a_abs;
            dvs     <= b_abs;
            cnt     <= CW'(N - 1);
            qneg    <= io.din0[N-1] ^ io.din1[D-1];
            io.busy <= 1'b1;
            if (io.din1 == '0) begin
              // Remainder register carries the raw dividend low bits so the
              // common FIX path yields remd = din0[15:0] unchanged.
              r     <= {1'b0, io.din0[D-1:0]};
              rneg  <= 1'b0;
              state <= FIX;
            end else begin
              r     <= '0;
              rneg  <= io.din0[N-1];
              state <= RUN;
            end
          end
        end
        RUN: begin
          q   <= {q[N-2:0], ge};
          r   <= r_nx;
          cnt <= cnt - 1'b1;
          if (cnt == '0) state <= FIX;
        end
        FIX: begin
          io.dout        <= zdiv ? '0 : (qneg ? dout_WIDTH'(-q) : dout_WIDTH'(q));
          io.remd        <= rneg ? D'(-r) : D'(r);
          io.ovf         <= !zdiv && (qneg ? (q > LIM) : (q >= LIM));
          io.div_by_zero <= zdiv;
          io.done        <= 1'b1;
          io.busy        <= 1'b0;
          state          <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
